// File: rtl/branch_predictor_param_pkg.sv
// Shared definitions for the parametrised fetch-stage branch predictor.
//   btype_e   : branch type encoding carried by the BTB and by EX updates
//   XLEN      : address width
//   RET_SKIP  : byte offset from a call to its return point (call + delay slot)
//   slot_pc() : pc of slot i within a sequential fetch group
package branch_predictor_param_pkg;

  typedef enum logic [1:0] {
    BT_NUL = 2'd0,  // conditional / not a control transfer
    BT_CAL = 2'd1,
    BT_RET = 2'd2,
    BT_J   = 2'd3
  } btype_e;

  localparam int XLEN     = 32;
  localparam int RET_SKIP = 8;

  function automatic logic [XLEN-1:0] slot_pc(input logic [XLEN-1:0] base, input int slot);
    return base + XLEN'(4 * slot);
  endfunction

endpackage

// File: rtl/branch_predictor_param_ras.sv
// Circular return-address stack.
//   clk, rst          : clock, synchronous active-high reset (top/count only)
//   restore           : replace top/count with rest_top / (rest_nz ? 1 : 0) before push/pop
//   push, pop         : applied on top of the (possibly restored) pointer
//   push_val          : address written on push
//   top, nz           : current top pointer and count>0 flag (checkpoint source)
//   top_val           : entry at top
// A push when full wraps and overwrites the oldest entry; count saturates at DEPTH.
// A pop when empty leaves both top and count alone.
module branch_predictor_param_ras
  import branch_predictor_param_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restore,
  input  logic [PW-1:0]   rest_top,
  input  logic            rest_nz,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_val,
  output logic [PW-1:0]   top,
  output logic            nz,
  output logic [XLEN-1:0] top_val
);

  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [XLEN-1:0] stack [DEPTH];
  logic [PW-1:0]   top_r, b_top, up_top;
  logic [PW:0]     cnt_r, b_cnt;

  // base pointer: recovery replaces the live state before the branch's own push/pop
  always_comb begin
    b_top  = restore ? rest_top : top_r;
    b_cnt  = restore ? {{PW{1'b0}}, rest_nz} : cnt_r;
    up_top = b_top + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_r <= '0;
      cnt_r <= '0;
    end else if (push) begin
      top_r <= up_top;
      cnt_r <= (b_cnt == FULL) ? b_cnt : b_cnt + 1'b1;
    end else if (pop && b_cnt != '0) begin
      top_r <= b_top - 1'b1;
      cnt_r <= b_cnt - 1'b1;
    end else begin
      top_r <= b_top;
      cnt_r <= b_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) stack[up_top] <= push_val;
  end

  assign top     = top_r;
  assign nz      = (cnt_r != '0);
  assign top_val = stack[top_r];

endmodule

// File: rtl/branch_predictor_param.sv
// Fetch-stage predictor: direct-mapped BTB with saturating counters plus a
// speculative RAS with checkpoint recovery, trained by EX.
//   clk, resetn     : clock, synchronous active-high reset
//   stall           : suppresses speculative RAS update
//   pc              : fetch-group base; slot i looks up pc + 4*i
//   pred_hit_o      : per-slot BTB hit
//   pred_taken_o    : per-slot taken, only the lowest taken slot set
//   pred_target_o   : per-slot target, slot i at [32*i+31:32*i]
//   pred_ckpt_o     : {count>0, top} RAS checkpoint
//   upd_*           : one resolved branch from EX (training and mispredict recovery)
module branch_predictor_param
  import branch_predictor_param_pkg::*;
#(
  parameter int FETCH_W   = 2,
  parameter int IDX_W     = 8,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 16,
  parameter int RAS_PW    = $clog2(RAS_DEPTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    stall,
  input  logic [31:0]             pc,
  output logic [FETCH_W-1:0]      pred_hit_o,
  output logic [FETCH_W-1:0]      pred_taken_o,
  output logic [FETCH_W*32-1:0]   pred_target_o,
  output logic [RAS_PW:0]         pred_ckpt_o,
  input  logic                    upd_valid,
  input  logic [31:0]             upd_pc,
  input  logic                    upd_taken,
  input  logic [31:0]             upd_target,
  input  logic [1:0]              upd_type,
  input  logic                    upd_mispredict,
  input  logic [RAS_PW:0]         upd_ckpt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;
  localparam logic [CNT_W-1:0] CTR_INIT = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CTR_MAX  = '1;

  // BTB state; only valid bits are reset
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_arr [ENTRIES];
  logic [31:0]        tgt_arr [ENTRIES];
  logic [1:0]         typ_arr [ENTRIES];
  logic [CNT_W-1:0]   ctr_arr [ENTRIES];

  logic [RAS_PW-1:0] ras_top;
  logic              ras_nz;
  logic [31:0]       ras_val;

  logic [FETCH_W-1:0]       hit_raw, take_raw, take_msk;
  logic [FETCH_W-1:0][31:0] s_pc, s_tgt;
  logic [FETCH_W-1:0][1:0]  s_typ;

  // per-slot lookup
  for (genvar i = 0; i < FETCH_W; i++) begin : g_slot
    logic [IDX_W-1:0] sidx;
    assign s_pc[i]     = slot_pc(pc, i);
    assign sidx        = s_pc[i][IDX_W+1:2];
    assign hit_raw[i]  = valid[sidx] && (tag_arr[sidx] == s_pc[i][31:IDX_W+2]);
    assign s_typ[i]    = typ_arr[sidx];
    assign take_raw[i] = hit_raw[i] && (s_typ[i] != BT_NUL || ctr_arr[sidx][CNT_W-1]);
    assign s_tgt[i]    = !hit_raw[i]                    ? '0 :
                         (s_typ[i] == BT_RET && ras_nz) ? ras_val : tgt_arr[sidx];
  end

  // keep only the first taken slot; it alone drives the speculative RAS op
  logic        found;
  logic [1:0]  sel_typ;
  logic [31:0] sel_pc;
  always_comb begin
    found    = 1'b0;
    take_msk = '0;
    sel_typ  = BT_NUL;
    sel_pc   = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (take_raw[i] && !found) begin
        take_msk[i] = 1'b1;
        sel_typ     = s_typ[i];
        sel_pc      = s_pc[i];
      end
      found = found | take_raw[i];
    end
  end

  assign pred_hit_o    = resetn ? '0 : hit_raw;
  assign pred_taken_o  = resetn ? '0 : take_msk;
  assign pred_target_o = resetn ? '0 : s_tgt;
  assign pred_ckpt_o   = resetn ? '0 : {ras_nz, ras_top};

  // recovery wins over the same-cycle speculative op
  logic recover, spec, ras_push, ras_pop;
  logic [31:0] push_val;
  always_comb begin
    recover  = upd_valid && upd_mispredict;
    spec     = !stall && !recover && found;
    ras_push = recover ? (upd_type == BT_CAL) : (spec && sel_typ == BT_CAL);
    ras_pop  = recover ? (upd_type == BT_RET) : (spec && sel_typ == BT_RET);
    push_val = recover ? upd_pc + 32'(RET_SKIP) : sel_pc + 32'(RET_SKIP);
  end

  branch_predictor_param_ras #(.DEPTH(RAS_DEPTH), .PW(RAS_PW)) u_ras (
    .clk     (clk),
    .rst     (resetn),
    .restore (recover),
    .rest_top(upd_ckpt[RAS_PW-1:0]),
    .rest_nz (upd_ckpt[RAS_PW]),
    .push    (ras_push),
    .pop     (ras_pop),
    .push_val(push_val),
    .top     (ras_top),
    .nz      (ras_nz),
    .top_val (ras_val)
  );

  // training
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit, u_alloc;
  logic [CNT_W-1:0] u_ctr;
  always_comb begin
    u_idx   = upd_pc[IDX_W+1:2];
    u_tag   = upd_pc[31:IDX_W+2];
    u_hit   = valid[u_idx] && (tag_arr[u_idx] == u_tag);
    u_alloc = !u_hit && (upd_taken || upd_type != BT_NUL);
    u_ctr   = ctr_arr[u_idx];
    if (upd_taken) u_ctr = (u_ctr == CTR_MAX) ? u_ctr : u_ctr + 1'b1;
    else           u_ctr = (u_ctr == '0)      ? u_ctr : u_ctr - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (resetn)                    valid        <= '0;
    else if (upd_valid && u_alloc) valid[u_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn && upd_valid) begin
      if (u_hit) begin
        ctr_arr[u_idx] <= u_ctr;
        tgt_arr[u_idx] <= upd_target;
        typ_arr[u_idx] <= upd_type;
      end else if (u_alloc) begin
        tag_arr[u_idx] <= u_tag;
        tgt_arr[u_idx] <= upd_target;
        typ_arr[u_idx] <= upd_type;
        ctr_arr[u_idx] <= CTR_INIT;
      end
    end
  end

  // word-aligned pcs: the byte-offset bits never matter
  logic unused_lsb;
  assign unused_lsb = ^{pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor_param.sv
module tb_branch_predictor_param;
  import branch_predictor_param_pkg::*;

  logic        clk = 0;
  logic        resetn = 1;
  logic        stall = 1;
  logic [31:0] pc = 32'h1000;
  logic [1:0]  pred_hit_o, pred_taken_o;
  logic [63:0] pred_target_o;
  logic [4:0]  pred_ckpt_o;
  logic        upd_valid = 0;
  logic [31:0] upd_pc = 0;
  logic        upd_taken = 0;
  logic [31:0] upd_target = 0;
  logic [1:0]  upd_type = 0;
  logic        upd_mispredict = 0;
  logic [4:0]  upd_ckpt = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_predictor_param dut (
    .clk(clk), .resetn(resetn), .stall(stall), .pc(pc),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .pred_ckpt_o(pred_ckpt_o),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_type(upd_type),
    .upd_mispredict(upd_mispredict), .upd_ckpt(upd_ckpt)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // one-cycle EX update with stall held so no speculation happens
  task automatic upd(input logic [31:0] a, input logic tk, input logic [31:0] t, input logic [1:0] ty);
    upd_valid = 1; upd_pc = a; upd_taken = tk; upd_target = t; upd_type = ty;
    cyc();
    upd_valid = 0;
  endtask

  // one unstalled fetch cycle at pc
  task automatic fetch(input logic [31:0] a);
    pc = a; stall = 0;
    cyc();
    stall = 1;
  endtask

  typedef struct {
    bit          du;
    logic [31:0] upc;
    bit          utk;
    logic [31:0] utgt;
    logic [1:0]  utyp;
    logic [31:0] fpc;
    bit          spec;
    logic [1:0]  ehit;
    logic [1:0]  etk;
    logic [31:0] et0;
    logic [31:0] et1;
    logic [4:0]  eck;
  } vec_t;

  vec_t tv [11];
  logic [4:0] ck;

  initial begin
    //            du upc        tk tgt          typ     fpc        sp hit    tk     t0           t1           ck
    tv[0]  = '{0, 32'h0,    0, 32'h0,    BT_NUL, 32'h1000, 0, 2'b00, 2'b00, 32'h0,    32'h0,    5'h00};
    tv[1]  = '{1, 32'h1004, 1, 32'h2000, BT_NUL, 32'h1000, 0, 2'b10, 2'b10, 32'h0,    32'h2000, 5'h00};
    tv[2]  = '{1, 32'h1004, 1, 32'h2000, BT_NUL, 32'h1000, 0, 2'b10, 2'b10, 32'h0,    32'h2000, 5'h00};
    tv[3]  = '{1, 32'h1004, 1, 32'h2000, BT_NUL, 32'h1000, 0, 2'b10, 2'b10, 32'h0,    32'h2000, 5'h00};
    tv[4]  = '{1, 32'h1004, 0, 32'h2000, BT_NUL, 32'h1000, 0, 2'b10, 2'b10, 32'h0,    32'h2000, 5'h00};
    tv[5]  = '{1, 32'h1004, 0, 32'h2000, BT_NUL, 32'h1000, 0, 2'b10, 2'b00, 32'h0,    32'h2000, 5'h00};
    tv[6]  = '{1, 32'h1000, 1, 32'h3000, BT_CAL, 32'h1000, 0, 2'b11, 2'b01, 32'h3000, 32'h2000, 5'h00};
    tv[7]  = '{1, 32'h1004, 1, 32'h5000, BT_J,   32'h1000, 1, 2'b11, 2'b01, 32'h3000, 32'h5000, 5'h00};
    tv[8]  = '{1, 32'h3010, 1, 32'h7000, BT_RET, 32'h3010, 1, 2'b01, 2'b01, 32'h1008, 32'h0,    5'h11};
    tv[9]  = '{0, 32'h0,    0, 32'h0,    BT_NUL, 32'h3010, 1, 2'b01, 2'b01, 32'h7000, 32'h0,    5'h00};
    tv[10] = '{0, 32'h0,    0, 32'h0,    BT_NUL, 32'h3010, 0, 2'b01, 2'b01, 32'h7000, 32'h0,    5'h00};

    // reset with outputs forced low
    cyc(); cyc();
    chk("rst_hit", 32'(pred_hit_o), 0);
    chk("rst_ckpt", 32'(pred_ckpt_o), 0);
    resetn = 0;

    for (int r = 0; r < 11; r++) begin
      if (tv[r].du) upd(tv[r].upc, tv[r].utk, tv[r].utgt, tv[r].utyp);
      pc = tv[r].fpc; #1;
      chk($sformatf("v%0d_hit", r),   32'(pred_hit_o),   32'(tv[r].ehit));
      chk($sformatf("v%0d_taken", r), 32'(pred_taken_o), 32'(tv[r].etk));
      chk($sformatf("v%0d_t0", r),    pred_target_o[31:0],  tv[r].et0);
      chk($sformatf("v%0d_t1", r),    pred_target_o[63:32], tv[r].et1);
      chk($sformatf("v%0d_ckpt", r),  32'(pred_ckpt_o),  32'(tv[r].eck));
      if (tv[r].spec) fetch(tv[r].fpc);
    end

    // overflow: 18 distinct calls into a 16-entry stack (top was 0, empty)
    for (int k = 0; k < 18; k++) upd(32'h8100 + 32'(8*k), 1, 32'h9000, BT_CAL);
    for (int k = 0; k < 18; k++) fetch(32'h8100 + 32'(8*k));
    #1 chk("ovf_ckpt", 32'(pred_ckpt_o), 32'h12);
    pc = 32'h3010;
    for (int i = 0; i < 16; i++) begin
      #1 chk($sformatf("pop%0d", i), pred_target_o[31:0], 32'h8108 + 32'(8*(17-i)));
      fetch(32'h3010);
    end
    #1 chk("drain_t0", pred_target_o[31:0], 32'h7000);
    chk("drain_ckpt", 32'(pred_ckpt_o), 32'h02);

    // recovery: push A, capture ckpt, push B, mispredicted CAL restores + same-cycle spec push
    fetch(32'h8100);
    ck = pred_ckpt_o;
    chk("ckpt_a", 32'(ck), 32'h13);
    fetch(32'h8108);
    upd_valid = 1; upd_mispredict = 1; upd_pc = 32'h4000; upd_taken = 1;
    upd_target = 32'h6000; upd_type = BT_CAL; upd_ckpt = ck;
    fetch(32'h8100);
    upd_valid = 0; upd_mispredict = 0;
    pc = 32'h3010; #1;
    chk("rec_t0", pred_target_o[31:0], 32'h4008);
    chk("rec_ckpt", 32'(pred_ckpt_o), 32'h14);
    fetch(32'h3010); #1;
    chk("rec_pop_t0", pred_target_o[31:0], 32'h8108);
    chk("rec_pop_ckpt", 32'(pred_ckpt_o), 32'h13);
    fetch(32'h3010); #1;
    chk("rec_empty_t0", pred_target_o[31:0], 32'h7000);
    chk("rec_empty_ckpt", 32'(pred_ckpt_o), 32'h02);

    // reset mid-operation dominates update and speculation
    resetn = 1; stall = 0; pc = 32'h3010;
    upd_valid = 1; upd_pc = 32'h2000; upd_taken = 1; upd_target = 32'hA000; upd_type = BT_J;
    #1;
    chk("mid_rst_hit", 32'(pred_hit_o), 0);
    chk("mid_rst_t0", pred_target_o[31:0], 0);
    cyc(); cyc();
    resetn = 0; upd_valid = 0; stall = 1; #1;
    chk("post_rst_hit", 32'(pred_hit_o), 0);
    chk("post_rst_ckpt", 32'(pred_ckpt_o), 0);
    pc = 32'h2000; #1;
    chk("post_rst_upd_dropped", 32'(pred_hit_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
